// File: rtl/fp_align_frontend.sv
// Single-precision add/sub operand front end: unpack and order by magnitude (S1),
// then right-align the smaller mantissa with guard/round/sticky (S2).
module fp_align_frontend #(
  parameter int SHIFT_SAT = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        op_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] man_big,
  output logic [31:0] man_small,
  output logic [7:0]  exp_out,
  output logic        sign_out,
  output logic        eff_sub,
  output logic [2:0]  flags
);
  localparam logic [7:0] SAT = 8'(SHIFT_SAT);

  logic [7:0]  exp_a, exp_b, expe_a, expe_b;
  logic [31:0] m_a, m_b;
  logic        a_big, inf_a, inf_b, nan_a, nan_b, zero_a, zero_b;
  logic        eff_sub_in, nan_in;
  logic [2:0]  flags_in;

  assign exp_a  = op_a[30:23];
  assign exp_b  = op_b[30:23];
  assign expe_a = (exp_a == 8'd0) ? 8'd1 : exp_a;
  assign expe_b = (exp_b == 8'd0) ? 8'd1 : exp_b;
  // Layout: 4 spare, ovf, hidden@26, frac, G, R, S.
  assign m_a    = {5'b0, exp_a != 8'd0, op_a[22:0], 3'b000};
  assign m_b    = {5'b0, exp_b != 8'd0, op_b[22:0], 3'b000};
  assign a_big  = op_a[30:0] >= op_b[30:0];

  assign inf_a      = (exp_a == 8'hFF) && (op_a[22:0] == 23'd0);
  assign inf_b      = (exp_b == 8'hFF) && (op_b[22:0] == 23'd0);
  assign nan_a      = (exp_a == 8'hFF) && (op_a[22:0] != 23'd0);
  assign nan_b      = (exp_b == 8'hFF) && (op_b[22:0] != 23'd0);
  assign zero_a     = op_a[30:0] == 31'd0;
  assign zero_b     = op_b[30:0] == 31'd0;
  assign eff_sub_in = op_a[31] ^ op_b[31] ^ op_sub;
  assign nan_in     = nan_a || nan_b || (inf_a && inf_b && eff_sub_in);
  assign flags_in   = {nan_in, (inf_a || inf_b) && !nan_in, zero_a && zero_b};

  logic        s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [31:0] s1_mbig_q, s1_mbig_d, s1_msmall_q, s1_msmall_d;
  logic [7:0]  s1_exp_q, s1_exp_d, s1_diff_q, s1_diff_d;
  logic        s1_sign_q, s1_sign_d, s1_eff_q, s1_eff_d;
  logic [2:0]  s1_flags_q, s1_flags_d;
  logic [31:0] s2_mbig_q, s2_mbig_d, s2_msmall_q, s2_msmall_d;
  logic [7:0]  s2_exp_q, s2_exp_d;
  logic        s2_sign_q, s2_sign_d, s2_eff_q, s2_eff_d;
  logic [2:0]  s2_flags_q, s2_flags_d;

  logic        in_fire, s2_load;
  logic [4:0]  shamt;
  logic [31:0] mask, aligned;
  logic        sticky;

  assign in_ready = !s1_v_q || !s2_v_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_v_q && (!s2_v_q || out_ready);

  always_comb begin
    s1_v_d      = s1_v_q;
    s1_mbig_d   = s1_mbig_q;
    s1_msmall_d = s1_msmall_q;
    s1_exp_d    = s1_exp_q;
    s1_diff_d   = s1_diff_q;
    s1_sign_d   = s1_sign_q;
    s1_eff_d    = s1_eff_q;
    s1_flags_d  = s1_flags_q;
    if (in_fire) begin
      s1_v_d      = 1'b1;
      s1_mbig_d   = a_big ? m_a : m_b;
      s1_msmall_d = a_big ? m_b : m_a;
      s1_exp_d    = a_big ? expe_a : expe_b;
      s1_diff_d   = a_big ? (expe_a - expe_b) : (expe_b - expe_a);
      s1_sign_d   = a_big ? op_a[31] : (op_b[31] ^ op_sub);
      s1_eff_d    = eff_sub_in;
      s1_flags_d  = flags_in;
    end else if (s2_load) begin
      s1_v_d = 1'b0;
    end
  end

  // Shift amounts of 27 and up are handled by the saturation path, so 5 bits suffice.
  always_comb begin
    shamt  = s1_diff_q[4:0];
    mask   = (32'd1 << shamt) - 32'd1;
    sticky = |(s1_msmall_q & mask);
    if (s1_diff_q >= SAT) begin
      aligned = {31'd0, |s1_msmall_q};
    end else begin
      aligned = (s1_msmall_q >> shamt) | {31'd0, sticky};
    end
  end

  always_comb begin
    s2_v_d      = s2_v_q;
    s2_mbig_d   = s2_mbig_q;
    s2_msmall_d = s2_msmall_q;
    s2_exp_d    = s2_exp_q;
    s2_sign_d   = s2_sign_q;
    s2_eff_d    = s2_eff_q;
    s2_flags_d  = s2_flags_q;
    if (s2_load) begin
      s2_v_d      = 1'b1;
      s2_mbig_d   = s1_mbig_q;
      s2_msmall_d = aligned;
      s2_exp_d    = s1_exp_q;
      s2_sign_d   = s1_sign_q;
      s2_eff_d    = s1_eff_q;
      s2_flags_d  = s1_flags_q;
    end else if (out_ready) begin
      s2_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      s1_mbig_q   <= '0;
      s1_msmall_q <= '0;
      s1_exp_q    <= '0;
      s1_diff_q   <= '0;
      s1_sign_q   <= 1'b0;
      s1_eff_q    <= 1'b0;
      s1_flags_q  <= '0;
      s2_v_q      <= 1'b0;
      s2_mbig_q   <= '0;
      s2_msmall_q <= '0;
      s2_exp_q    <= '0;
      s2_sign_q   <= 1'b0;
      s2_eff_q    <= 1'b0;
      s2_flags_q  <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_mbig_q   <= s1_mbig_d;
      s1_msmall_q <= s1_msmall_d;
      s1_exp_q    <= s1_exp_d;
      s1_diff_q   <= s1_diff_d;
      s1_sign_q   <= s1_sign_d;
      s1_eff_q    <= s1_eff_d;
      s1_flags_q  <= s1_flags_d;
      s2_v_q      <= s2_v_d;
      s2_mbig_q   <= s2_mbig_d;
      s2_msmall_q <= s2_msmall_d;
      s2_exp_q    <= s2_exp_d;
      s2_sign_q   <= s2_sign_d;
      s2_eff_q    <= s2_eff_d;
      s2_flags_q  <= s2_flags_d;
    end
  end

  assign out_valid = s2_v_q;
  assign man_big   = s2_mbig_q;
  assign man_small = s2_msmall_q;
  assign exp_out   = s2_exp_q;
  assign sign_out  = s2_sign_q;
  assign eff_sub   = s2_eff_q;
  assign flags     = s2_flags_q;
endmodule

// File: tb/tb_fp_align_frontend.sv
// Directed bench for fp_align_frontend: vector table, back-pressure and mid-stream reset.
module tb_fp_align_frontend;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [31:0] op_a, op_b, man_big, man_small;
  logic [7:0]  exp_out;
  logic        sign_out, eff_sub;
  logic [2:0]  flags;

  int checks = 0;
  int failures = 0;

  fp_align_frontend #(.SHIFT_SAT(27)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .out_valid(out_valid),
    .out_ready(out_ready), .man_big(man_big), .man_small(man_small),
    .exp_out(exp_out), .sign_out(sign_out), .eff_sub(eff_sub), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] mb;
    logic [31:0] ms;
    logic [7:0]  e;
    logic        s;
    logic        es;
    logic [2:0]  f;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  int          sent, got;
  bit          drop_seen, have_snap;
  logic [39:0] snap;

  initial begin
    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h04000000, 32'h04000000, 8'h7F, 1'b0, 1'b0, 3'b000};
    vecs[1]  = '{32'h40400000, 32'h3F000000, 1'b0, 32'h06000000, 32'h01000000, 8'h80, 1'b0, 1'b0, 3'b000};
    vecs[2]  = '{32'h3F000000, 32'h40400000, 1'b1, 32'h06000000, 32'h01000000, 8'h80, 1'b1, 1'b1, 3'b000};
    vecs[3]  = '{32'h3F800000, 32'h30800000, 1'b0, 32'h04000000, 32'h00000001, 8'h7F, 1'b0, 1'b0, 3'b000};
    vecs[4]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h06000000, 32'h00000001, 8'hFF, 1'b0, 1'b0, 3'b100};
    vecs[5]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h04000000, 32'h04000000, 8'hFF, 1'b0, 1'b1, 3'b100};
    vecs[6]  = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 32'h00000000, 8'h01, 1'b0, 1'b1, 3'b001};
    vecs[7]  = '{32'h3F800001, 32'h41800000, 1'b0, 32'h04000000, 32'h00400001, 8'h83, 1'b0, 1'b0, 3'b000};
    vecs[8]  = '{32'h4C000000, 32'h3F800001, 1'b0, 32'h04000000, 32'h00000003, 8'h98, 1'b0, 1'b0, 3'b000};
    vecs[9]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h04000000, 32'h00000001, 8'hFF, 1'b0, 1'b0, 3'b010};
    vecs[10] = '{32'h00000001, 32'h00800000, 1'b0, 32'h04000000, 32'h00000008, 8'h01, 1'b0, 1'b0, 3'b000};
    vecs[11] = '{32'hC0400000, 32'hBF000000, 1'b0, 32'h06000000, 32'h01000000, 8'h80, 1'b1, 1'b0, 3'b000};

    rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_man_big", man_big, 32'd0);
    chk("reset_flags", 32'(flags), 32'd0);
    rst_n = 1'b1;

    // Table: one pair at a time with the output always ready.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      op_a = vecs[i].a; op_b = vecs[i].b; op_sub = vecs[i].sub; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_latency1", i), 32'(out_valid), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_latency2", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_man_big", i), man_big, vecs[i].mb);
      chk($sformatf("v%0d_man_small", i), man_small, vecs[i].ms);
      chk($sformatf("v%0d_exp_out", i), 32'(exp_out), 32'(vecs[i].e));
      chk($sformatf("v%0d_sign_eff_flags", i), 32'({sign_out, eff_sub, flags}),
          32'({vecs[i].s, vecs[i].es, vecs[i].f}));
    end

    // Back-pressure: 4 pairs offered back to back, output stalled for the first 5 cycles.
    sent = 0; got = 0; drop_seen = 1'b0; have_snap = 1'b0; snap = '0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      if (sent < 4) begin
        in_valid = 1'b1;
        op_a = {1'b0, 8'h80 + 8'(sent), 23'd0};
        op_b = 32'h3F800000;
        op_sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!in_ready && !drop_seen) begin
        chk("bp_accepted_before_drop", 32'(sent), 32'd2);
        drop_seen = 1'b1;
      end
      if (out_valid && !out_ready) begin
        if (have_snap) chk("bp_stable", {24'd0, snap[39:32]} ^ man_small ^ snap[31:0], {24'd0, exp_out});
        snap = {exp_out, man_small};
        have_snap = 1'b1;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp%0d_exp_out", got), 32'(exp_out), 32'(8'h80 + 8'(got)));
        chk($sformatf("bp%0d_man_small", got), man_small, 32'h04000000 >> (got + 1));
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    chk("bp_in_ready_dropped", 32'(drop_seen), 32'd1);
    chk("bp_output_count", 32'(got), 32'd4);

    // Mid-stream reset: park a pair in S2, then drop rst_n between edges.
    @(negedge clk);
    out_ready = 1'b0;
    op_a = 32'h40400000; op_b = 32'h3F000000; op_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_man_big", man_big, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    op_a = 32'h3F800000; op_b = 32'h30800000; op_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(out_valid), 32'd1);
    chk("post_rst_man_small", man_small, 32'h00000001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
